// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, reads instruction memory over a req/valid
// handshake and presents the decoded fields of the held instruction downstream.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] pc_out,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm,
  output logic        illegal,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        misalign_err
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] instr;
  logic        accept, capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          capture   = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          accept    = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Redirects are forced to word alignment; the low bits only raise the sticky error.
  always_comb begin
    pc_nxt = pc + 32'd4;
    if (branch_taken) pc_nxt = {branch_target[31:2], 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      instr        <= NOP;
      misalign_err <= 1'b0;
    end else begin
      if (capture) instr <= imem_rdata;
      if (accept) begin
        pc <= pc_nxt;
        if (branch_taken && (branch_target[1:0] != 2'b00)) misalign_err <= 1'b1;
      end
    end
  end

  assign imem_addr = pc;
  assign pc_out    = pc;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  always_comb begin
    imm     = 32'd0;
    illegal = inst_valid;
    case (opcode)
      OP_I, OP_LOAD: begin
        imm     = {{20{instr[31]}}, instr[31:20]};
        illegal = 1'b0;
      end
      OP_STORE: begin
        imm     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        illegal = 1'b0;
      end
      OP_BRANCH: begin
        imm     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        illegal = 1'b0;
      end
      OP_R:    illegal = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory and downstream are driven from a single
// stimulus sequence and every output is compared to hand-computed values.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] pc_out;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        illegal;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        misalign_err;

  int n_vec = 0;
  int n_err = 0;

  fetch_unit #(.RESET_PC(32'h100)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .pc_out(pc_out), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .illegal(illegal),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled and inputs changed 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
    inst_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;
    #12;
    chk("rst_req",   imem_req, 0);
    chk("rst_ivld",  inst_valid, 0);
    chk("rst_op",    opcode, 7'h13);
    chk("rst_imm",   imm, 0);
    chk("rst_mis",   misalign_err, 0);
    chk("rst_ill",   illegal, 0);

    // Boot: one idle cycle, then fetch from RESET_PC
    step(); rst_n = 1'b1;
    chk("idle_req",  imem_req, 0);
    step();
    chk("boot_req",  imem_req, 1);
    chk("boot_addr", imem_addr, 32'h100);

    // Zero-wait fetch of addi x1,x0,5 with immediate accept
    imem_valid = 1'b1; imem_rdata = 32'h00500093; inst_ready = 1'b1;
    step(); imem_valid = 1'b0;
    chk("seq_ivld",  inst_valid, 1);
    chk("seq_req",   imem_req, 0);
    chk("seq_op",    opcode, 7'b0010011);
    chk("seq_rd",    rd, 1);
    chk("seq_rs1",   rs1, 0);
    chk("seq_imm",   imm, 5);
    chk("seq_pc",    pc_out, 32'h100);
    step();
    chk("seq_ivld2", inst_valid, 0);
    chk("seq_next",  imem_addr, 32'h104);

    // Three wait cycles, then a store held for four cycles without ready
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_req",  imem_req, 1);
      chk("wait_addr", imem_addr, 32'h104);
    end
    imem_valid = 1'b1; imem_rdata = 32'hFE112E23;
    branch_taken = 1'b1; branch_target = 32'h300;
    step(); imem_valid = 1'b0; imem_rdata = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      chk("stall_vld", inst_valid, 1);
      chk("stall_imm", imm, 32'hFFFFFFFC);
      chk("stall_pc",  pc_out, 32'h104);
      chk("stall_op",  opcode, 7'b0100011);
      step();
    end
    chk("stall_vld5", inst_valid, 1);
    inst_ready = 1'b1; branch_taken = 1'b0;
    step();
    chk("store_next", imem_addr, 32'h108);

    // Branch word, accepted with an aligned redirect
    imem_valid = 1'b1; imem_rdata = 32'hFE000EE3;
    branch_taken = 1'b1; branch_target = 32'h200;
    step(); imem_valid = 1'b0;
    chk("br_imm",    imm, 32'hFFFFFFFC);
    chk("br_ill",    illegal, 0);
    step();
    chk("redir_addr", imem_addr, 32'h200);
    chk("redir_mis",  misalign_err, 0);

    // R-type, accepted with a misaligned redirect
    imem_valid = 1'b1; imem_rdata = 32'h40208033; branch_target = 32'h206;
    step(); imem_valid = 1'b0;
    chk("r_imm",     imm, 0);
    chk("r_f7",      funct7, 7'b0100000);
    chk("r_rs2",     rs2, 2);
    chk("r_rs1",     rs1, 1);
    chk("r_ill",     illegal, 0);
    step();
    chk("mis_addr",  imem_addr, 32'h204);
    chk("mis_flag",  misalign_err, 1);

    // Unsupported opcode (jal) still handshakes; redirect to top of memory
    imem_valid = 1'b1; imem_rdata = 32'h0000006F; inst_ready = 1'b0;
    branch_taken = 1'b0;
    step(); imem_valid = 1'b0;
    chk("ill_flag",  illegal, 1);
    chk("ill_vld",   inst_valid, 1);
    chk("ill_imm",   imm, 0);
    inst_ready = 1'b1; branch_taken = 1'b1; branch_target = 32'hFFFFFFFC;
    step();
    chk("ill_done",  illegal, 0);
    chk("top_addr",  imem_addr, 32'hFFFFFFFC);
    chk("mis_stick", misalign_err, 1);

    // Sequential accept at the top address wraps to zero
    imem_valid = 1'b1; imem_rdata = 32'h00000013; branch_taken = 1'b0;
    step(); imem_valid = 1'b0;
    step();
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_mis",  misalign_err, 1);

    // Reset while waiting in fetch: request drops without a clock edge
    #2; rst_n = 1'b0; #1;
    chk("mid_req",   imem_req, 0);
    chk("mid_mis",   misalign_err, 0);
    imem_valid = 1'b1; imem_rdata = 32'h00700113;
    step(); step();
    chk("mid_op",    opcode, 7'h13);
    chk("mid_imm",   imm, 0);
    rst_n = 1'b1; imem_valid = 1'b0;
    chk("rel_req",   imem_req, 0);
    step();
    chk("rel_req2",  imem_req, 1);
    chk("rel_addr",  imem_addr, 32'h100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
